// File: rtl/power_of_n_iter.sv
// rtl/power_of_n_iter.sv - iterative LSB-first square-and-multiply power unit
// Computes base^exp with valid/ready handshakes and a saturating overflow flag.
module power_of_n_iter #(
   parameter int BASE_W = 8,
   parameter int EXP_W  = 4,
   parameter int OUT_W  = 64
) (
   input  logic              i_clock,
   input  logic              i_reset_async,
   input  logic              i_status,
   input  logic [BASE_W-1:0] i_base,
   input  logic [EXP_W-1:0]  i_exp,
   output logic              o_ready,
   output logic              o_status,
   output logic [OUT_W-1:0]  o_value,
   output logic              o_overflow,
   input  logic              i_ready
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state;
   logic [OUT_W-1:0]   acc;
   logic [OUT_W-1:0]   b;
   logic [EXP_W-1:0]   e;
   logic               ovf;
   logic               b_ovf;

   logic [2*OUT_W-1:0] mul_prod;
   logic [2*OUT_W-1:0] sq_prod;
   logic [EXP_W-1:0]   e_shift;
   logic               last_step;
   logic [OUT_W-1:0]   acc_next;
   logic               ovf_next;

   assign mul_prod  = {{OUT_W{1'b0}}, acc} * {{OUT_W{1'b0}}, b};
   assign sq_prod   = {{OUT_W{1'b0}}, b} * {{OUT_W{1'b0}}, b};
   assign e_shift   = e >> 1;
   assign last_step = (e_shift == '0);
   assign acc_next  = e[0] ? mul_prod[OUT_W-1:0] : acc;
   // A multiply by an already-overflowed b taints the result even if the low product fits.
   assign ovf_next  = ovf | (e[0] & (b_ovf | (|mul_prod[2*OUT_W-1:OUT_W])));

   always_ff @(posedge i_clock or posedge i_reset_async) begin
      if (i_reset_async) begin
         state      <= IDLE;
         acc        <= '0;
         b          <= '0;
         e          <= '0;
         ovf        <= 1'b0;
         b_ovf      <= 1'b0;
         o_ready    <= 1'b1;
         o_status   <= 1'b0;
         o_value    <= '0;
         o_overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_status) begin
                  e       <= i_exp;
                  b       <= OUT_W'(i_base);
                  acc     <= {{(OUT_W-1){1'b0}}, 1'b1};
                  ovf     <= 1'b0;
                  b_ovf   <= 1'b0;
                  o_ready <= 1'b0;
                  state   <= CALC;
               end
            end
            CALC: begin
               acc <= acc_next;
               ovf <= ovf_next;
               e   <= e_shift;
               // Skip the square on the final step so an unused b cannot raise overflow.
               if (!last_step) begin
                  b     <= sq_prod[OUT_W-1:0];
                  b_ovf <= b_ovf | (|sq_prod[2*OUT_W-1:OUT_W]);
               end else begin
                  o_value    <= ovf_next ? {OUT_W{1'b1}} : acc_next;
                  o_overflow <= ovf_next;
                  o_status   <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (i_ready) begin
                  o_status <= 1'b0;
                  o_ready  <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               o_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_power_of_n_iter.sv
// tb/tb_power_of_n_iter.sv - directed bench for power_of_n_iter
// Default instance plus a narrow BASE_W=9/OUT_W=16 instance for the width sweep.
module tb_power_of_n_iter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        s0, r0, rdy0, st0, ovf0;
   logic [7:0]  b0;
   logic [3:0]  e0;
   logic [63:0] v0;

   logic        s1, r1, rdy1, st1, ovf1;
   logic [8:0]  b1;
   logic [3:0]  e1;
   logic [15:0] v1;

   int checks = 0;
   int errors = 0;

   power_of_n_iter #(.BASE_W(8), .EXP_W(4), .OUT_W(64)) dut0 (
      .i_clock(clk), .i_reset_async(rst), .i_status(s0), .i_base(b0), .i_exp(e0),
      .o_ready(rdy0), .o_status(st0), .o_value(v0), .o_overflow(ovf0), .i_ready(r0)
   );

   power_of_n_iter #(.BASE_W(9), .EXP_W(4), .OUT_W(16)) dut1 (
      .i_clock(clk), .i_reset_async(rst), .i_status(s1), .i_base(b1), .i_exp(e1),
      .o_ready(rdy1), .o_status(st1), .o_value(v1), .o_overflow(ovf1), .i_ready(r1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts an operation on dut0 from a negedge and waits for o_status, checking latency.
   task automatic op0(input logic [7:0] b, input logic [3:0] e, input logic [63:0] ev,
                      input logic eo, input int lat, input string tag);
      int cnt;
      chk({tag, "_ready"}, 64'(rdy0), 64'd1);
      s0 = 1'b1; b0 = b; e0 = e;
      @(posedge clk);
      @(negedge clk);
      s0 = 1'b0;
      chk({tag, "_busy"}, 64'(rdy0), 64'd0);
      cnt = 0;
      while (!st0 && cnt < 40) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
      chk({tag, "_status"}, 64'(st0), 64'd1);
      chk({tag, "_lat"}, 64'(cnt), 64'(lat));
      chk({tag, "_value"}, v0, ev);
      chk({tag, "_ovf"}, 64'(ovf0), 64'(eo));
   endtask

   task automatic release0(input string tag);
      r0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_st_low"}, 64'(st0), 64'd0);
      chk({tag, "_rdy_high"}, 64'(rdy0), 64'd1);
   endtask

   task automatic op1(input logic [8:0] b, input logic [3:0] e, input logic [15:0] ev,
                      input logic eo, input string tag);
      int cnt;
      s1 = 1'b1; b1 = b; e1 = e;
      @(posedge clk);
      @(negedge clk);
      s1 = 1'b0;
      cnt = 0;
      while (!st1 && cnt < 40) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
      chk({tag, "_status"}, 64'(st1), 64'd1);
      chk({tag, "_value"}, 64'(v1), 64'(ev));
      chk({tag, "_ovf"}, 64'(ovf1), 64'(eo));
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_rdy_high"}, 64'(rdy1), 64'd1);
   endtask

   initial begin
      int lat8 [10];
      logic seen;
      lat8 = '{1, 1, 2, 2, 3, 3, 3, 3, 4, 4};
      rst = 1'b1;
      s0 = 1'b0; b0 = '0; e0 = '0; r0 = 1'b1;
      s1 = 1'b0; b1 = '0; e1 = '0; r1 = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(rdy0), 64'd1);
      chk("rst_status", 64'(st0), 64'd0);
      chk("rst_value", v0, 64'd0);
      chk("rst_ovf", 64'(ovf0), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Legacy power-of-eight sequence, back-to-back with i_ready high.
      for (int k = 0; k < 10; k++) begin
         op0(8'd8, 4'(k), 64'd1 << (3 * k), 1'b0, lat8[k], $sformatf("pow8_%0d", k));
         release0($sformatf("pow8_%0d_rel", k));
      end

      op0(8'd3, 4'd13, 64'd1594323, 1'b0, 4, "b3e13");
      release0("b3e13_rel");
      op0(8'd0, 4'd0, 64'd1, 1'b0, 1, "b0e0");
      release0("b0e0_rel");
      op0(8'd0, 4'd5, 64'd0, 1'b0, 3, "b0e5");
      release0("b0e5_rel");
      op0(8'd1, 4'd15, 64'd1, 1'b0, 4, "b1e15");
      release0("b1e15_rel");

      op0(8'd255, 4'd8, 64'd17878103347812890625, 1'b0, 4, "b255e8");
      release0("b255e8_rel");
      op0(8'd255, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4, "b255e9");
      release0("b255e9_rel");
      op0(8'd255, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4, "b255e15");
      release0("b255e15_rel");

      // Backpressure: result held while a new request is offered and ignored.
      r0 = 1'b0;
      op0(8'd2, 4'd3, 64'd8, 1'b0, 2, "bp");
      for (int i = 0; i < 5; i++) begin
         s0 = 1'b1; b0 = 8'd5; e0 = 4'd2;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("bp_hold_st_%0d", i), 64'(st0), 64'd1);
         chk($sformatf("bp_hold_val_%0d", i), v0, 64'd8);
         chk($sformatf("bp_hold_rdy_%0d", i), 64'(rdy0), 64'd0);
      end
      s0 = 1'b0;
      release0("bp_rel");
      @(posedge clk);
      @(negedge clk);
      chk("bp_idle_rdy", 64'(rdy0), 64'd1);
      chk("bp_idle_st", 64'(st0), 64'd0);

      // Reset two cycles into a long calculation.
      s0 = 1'b1; b0 = 8'd3; e0 = 4'd15;
      @(posedge clk);
      @(negedge clk);
      s0 = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_status", 64'(st0), 64'd0);
      chk("mid_rst_value", v0, 64'd0);
      chk("mid_rst_ovf", 64'(ovf0), 64'd0);
      chk("mid_rst_ready", 64'(rdy0), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (st0) seen = 1'b1;
      end
      chk("mid_rst_no_pulse", 64'(seen), 64'd0);
      op0(8'd2, 4'd10, 64'd1024, 1'b0, 4, "after_rst");
      release0("after_rst_rel");

      op1(9'd2, 4'd15, 16'd32768, 1'b0, "w16_b2e15");
      op1(9'd256, 4'd2, 16'hFFFF, 1'b1, "w16_b256e2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/power_of_n_iter.md
Name: power_of_n_iter

Overview:
Parametrised successor to the fixed power-of-eight unit. Computes o_value = base^exponent for a runtime base and exponent, using iterative LSB-first square-and-multiply. Uses a valid/ready handshake on both sides, variable latency and a saturating overflow flag. Sits in the same datapath slot as the power-of-eight block, with widths set per instance.

Parameters:
BASE_W, 8, width of input base (unsigned)
EXP_W, 4, width of input exponent (unsigned)
OUT_W, 64, width of result; must be >= BASE_W

Ports:
i_clock  input  1  system clock, rising edge
i_reset_async  input  1  asynchronous, active-high reset
i_status  input  1  input valid
i_base  input  BASE_W  base operand
i_exp  input  EXP_W  exponent operand
o_ready  output  1  block can accept an operand pair
o_status  output  1  result valid
o_value  output  OUT_W  result; all-ones when o_overflow=1
o_overflow  output  1  true result exceeds 2^OUT_W-1
i_ready  input  1  downstream accepts result

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, o_ready=1, o_status=0, o_value=0, o_overflow=0, internal acc/b/e/b_ovf cleared.
- Reset mid-operation: the current operation is aborted with no output, and the block returns to IDLE.
- All outputs are registered.
- States: IDLE, CALC, DONE.
- IDLE:
  - o_ready=1.
  - On a posedge with i_status=1, latch the operands and go to CALC: e=i_exp; b=i_base zero-extended to OUT_W; acc=1; ovf=0; b_ovf=0.
  - Otherwise stay in IDLE.
- CALC: o_ready=0. Each cycle:
  - If e[0]=1: acc <= low OUT_W bits of acc*b (full 2*OUT_W product computed). Set ovf if b_ovf=1 or the product's upper OUT_W bits are nonzero.
  - If (e>>1)!=0: b <= b*b. Set b_ovf (sticky) if the square's upper bits are nonzero.
  - If (e>>1)==0: no square is performed, so there is no spurious overflow on the final step.
  - e <= e>>1.
  - If (e>>1)==0: go to DONE. o_value <= ovf_next ? all-ones : acc_next. o_overflow <= ovf_next. o_status <= 1.
- CALC latency: max(1, bit-length of exp) cycles. exp=0 takes 1 cycle with no multiply and gives result 1.
- DONE:
  - o_status=1, o_ready=0.
  - o_value and o_overflow are held stable until a posedge with i_ready=1. At that edge: o_status <= 0, go to IDLE.
  - i_status is ignored outside IDLE.
- Initiation interval: CALC cycles + 2 when i_ready is tied high.
- Edge cases:
  - 0^0=1. 0^n=0 for n>0, no overflow.
  - 1^n=1.
  - b_ovf can never be set when base<=1.
- Arithmetic is unsigned throughout; there are no signed modes.

Test Plan:
- Legacy equivalence (BASE_W=8, EXP_W=4, OUT_W=64): base=8, exp=0..9 back-to-back with i_ready=1 -> o_value = 1, 8, 64, ..., 134217728; o_overflow=0. Exp 9 gives o_status exactly 4 cycles after the accept edge plus 1 registered edge.
- Generic: base=3, exp=13 -> 1594323. base=0, exp=0 -> 1. base=0, exp=5 -> 0. base=1, exp=15 -> 1. All with o_overflow=0.
- Overflow boundary:
  - base=255, exp=8 -> 17878103347812890625, o_overflow=0 (no spurious flag from the final square).
  - base=255, exp=9 -> o_value=0xFFFFFFFFFFFFFFFF, o_overflow=1.
  - base=255, exp=15 -> same saturated result.
- Backpressure: result ready with i_ready=0 for 5 cycles -> o_status stays 1, o_value stable, o_ready=0, and a new i_status is ignored. Raising i_ready -> one transfer, o_ready=1 on the next cycle.
- Reset mid-CALC: base=3, exp=15, assert i_reset_async 2 cycles after accept -> outputs go to 0 immediately, no o_status pulse. Next op base=2, exp=10 -> 1024.
- Width sweep: rerun with OUT_W=16 -> 2^15=32768 with no overflow; 2^16 is not reachable with EXP_W=4. base=256 (BASE_W=9), exp=2 -> o_overflow=1, saturated 0xFFFF.
